dmem_arbiter: RTL and testbench

Two-port arbiter plus the shared 16x4 data memory that the 4-bit CPU core and a host/debug loader both access.
- Port 0: CPU (operand load, ALU result write-back). Port 1: host (preload, inspect).
- Round-robin grant, one access per cycle, optional bus lock for read-read-write ALU sequences, lock timeout for fairness.

---
 rtl/dmem_arbiter_pkg.sv | 29 ++
 rtl/dmem_arbiter_if.sv | 40 ++++
 rtl/dmem_arbiter_ram.sv | 34 +++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module   : dmem_arbiter_pkg
// Purpose  : Shared port indices, owner encodings, FSM state type and default
//            data-memory geometry for the CPU core and the dmem arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package dmem_arbiter_pkg;

    localparam int PORT_CPU    = 0;
    localparam int PORT_HOST   = 1;

    localparam int DMEM_ADDR_W = 4;
    localparam int DMEM_DATA_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_HOST = 2'b10
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Two-requester data-memory bus (CPU port 0, host port 1).
// Revision : 1.0 - initial release
//==============================================================================
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) ();

    logic              req0,   req1;
    logic              we0,    we1;
    logic              lock0,  lock1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0,   gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [1:0]        owner;
    logic              lock_timeout;

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
               addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               owner, lock_timeout
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
               addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               owner, lock_timeout
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_ram.sv
`default_nettype none
//==============================================================================
// Module   : dmem_arbiter_ram
// Purpose  : Single-port synchronous RAM, registered read data, no reset.
// Revision : 1.0 - initial release
//==============================================================================
module dmem_arbiter_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin two-port arbiter with bus lock and lock timeout in
//            front of the shared data memory.
// Revision : 1.0 - initial release
//==============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_LOCK = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);

    localparam logic [3:0] c_max_lock = 4'(MAX_LOCK);

    arb_state_e        r_state, w_state_nxt;
    logic              r_ptr, w_ptr_nxt;
    logic [3:0]        r_lock_cnt, w_lock_cnt_nxt;
    logic              w_gnt0, w_gnt1, w_force_rel;
    logic              r_lock_timeout;
    logic              r_rvalid0, r_rvalid1;
    logic [DATA_W-1:0] r_rdata0_hold, r_rdata1_hold;

    logic              w_ram_we, w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;

    always_comb begin
        w_gnt0         = 1'b0;
        w_gnt1         = 1'b0;
        w_force_rel    = 1'b0;
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.req0 && (!bus.req1 || (r_ptr == 1'b0))) begin
                    w_gnt0    = 1'b1;
                    w_ptr_nxt = 1'b1;
                    if (bus.lock0) begin
                        w_state_nxt    = ST_OWN0;
                        w_lock_cnt_nxt = 4'd1;
                    end
                end else if (bus.req1) begin
                    w_gnt1    = 1'b1;
                    w_ptr_nxt = 1'b0;
                    if (bus.lock1) begin
                        w_state_nxt    = ST_OWN1;
                        w_lock_cnt_nxt = 4'd1;
                    end
                end
            end
            ST_OWN0: begin
                // Timeout release grants nobody so the waiting port goes next.
                if (r_lock_cnt == c_max_lock) begin
                    w_force_rel    = 1'b1;
                    w_state_nxt    = ST_IDLE;
                    w_ptr_nxt      = 1'b1;
                    w_lock_cnt_nxt = 4'd0;
                end else begin
                    w_gnt0 = bus.req0;
                    if (bus.req0) begin
                        w_ptr_nxt = 1'b1;
                    end
                    if (!bus.lock0) begin
                        w_state_nxt    = ST_IDLE;
                        w_lock_cnt_nxt = 4'd0;
                    end else begin
                        w_lock_cnt_nxt = r_lock_cnt + 4'd1;
                    end
                end
            end
            ST_OWN1: begin
                if (r_lock_cnt == c_max_lock) begin
                    w_force_rel    = 1'b1;
                    w_state_nxt    = ST_IDLE;
                    w_ptr_nxt      = 1'b0;
                    w_lock_cnt_nxt = 4'd0;
                end else begin
                    w_gnt1 = bus.req1;
                    if (bus.req1) begin
                        w_ptr_nxt = 1'b0;
                    end
                    if (!bus.lock1) begin
                        w_state_nxt    = ST_IDLE;
                        w_lock_cnt_nxt = 4'd0;
                    end else begin
                        w_lock_cnt_nxt = r_lock_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_lock_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_ptr          <= 1'b0;
            r_lock_cnt     <= 4'd0;
            r_lock_timeout <= 1'b0;
            r_rvalid0      <= 1'b0;
            r_rvalid1      <= 1'b0;
            r_rdata0_hold  <= '0;
            r_rdata1_hold  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_ptr          <= w_ptr_nxt;
            r_lock_cnt     <= w_lock_cnt_nxt;
            r_lock_timeout <= w_force_rel;
            r_rvalid0      <= w_gnt0 && !bus.we0;
            r_rvalid1      <= w_gnt1 && !bus.we1;
            if (r_rvalid0) begin
                r_rdata0_hold <= w_ram_rdata;
            end
            if (r_rvalid1) begin
                r_rdata1_hold <= w_ram_rdata;
            end
        end
    end

    assign w_ram_we    = (w_gnt0 && bus.we0) || (w_gnt1 && bus.we1);
    assign w_ram_re    = (w_gnt0 && !bus.we0) || (w_gnt1 && !bus.we1);
    assign w_ram_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_ram_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;

    dmem_arbiter_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // RAM output is live only in the rvalid cycle; the hold register keeps it after.
    assign bus.gnt0         = w_gnt0;
    assign bus.gnt1         = w_gnt1;
    assign bus.rvalid0      = r_rvalid0;
    assign bus.rvalid1      = r_rvalid1;
    assign bus.rdata0       = r_rvalid0 ? w_ram_rdata : r_rdata0_hold;
    assign bus.rdata1       = r_rvalid1 ? w_ram_rdata : r_rdata1_hold;
    assign bus.lock_timeout = r_lock_timeout;

    always_comb begin
        case (r_state)
            ST_OWN0: bus.owner = OWN_CPU;
            ST_OWN1: bus.owner = OWN_HOST;
            default: bus.owner = OWN_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench with a read-data scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
module tb_dmem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .ADDR_W   (4),
        .DATA_W   (4),
        .MAX_LOCK (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [3:0] model_mem [16];
    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    bit         pend0 = 1'b0;
    bit         pend1 = 1'b0;
    logic [3:0] last0 = 4'd0;
    logic [3:0] last1 = 4'd0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int p, input bit rq, input bit w, input bit lk,
                       input logic [3:0] a, input logic [3:0] d);
        if (p == 0) begin
            bus.req0 = rq; bus.we0 = w; bus.lock0 = lk; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = rq; bus.we1 = w; bus.lock1 = lk; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic idle_all();
        drv(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        drv(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    // One clock cycle: check outputs mid-cycle, update the model, advance.
    task automatic cycle(input bit eg0, input bit eg1, input logic [1:0] eown, input bit elt);
        @(negedge clk);
        chk("gnt0", 8'(bus.gnt0), 8'(eg0));
        chk("gnt1", 8'(bus.gnt1), 8'(eg1));
        chk("owner", 8'(bus.owner), 8'(eown));
        chk("lock_timeout", 8'(bus.lock_timeout), 8'(elt));
        chk("rvalid0", 8'(bus.rvalid0), 8'(pend0));
        chk("rvalid1", 8'(bus.rvalid1), 8'(pend1));
        if (pend0 && q0.size() > 0) last0 = q0.pop_front();
        if (pend1 && q1.size() > 0) last1 = q1.pop_front();
        chk("rdata0", 8'(bus.rdata0), 8'(last0));
        chk("rdata1", 8'(bus.rdata1), 8'(last1));
        if (eg0) begin
            if (bus.we0) model_mem[bus.addr0] = bus.wdata0;
            else         q0.push_back(model_mem[bus.addr0]);
        end
        if (eg1) begin
            if (bus.we1) model_mem[bus.addr1] = bus.wdata1;
            else         q1.push_back(model_mem[bus.addr1]);
        end
        pend0 = eg0 && !bus.we0;
        pend1 = eg1 && !bus.we1;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_check();
        chk("rst_gnt0", 8'(bus.gnt0), 8'd0);
        chk("rst_gnt1", 8'(bus.gnt1), 8'd0);
        chk("rst_rvalid0", 8'(bus.rvalid0), 8'd0);
        chk("rst_rvalid1", 8'(bus.rvalid1), 8'd0);
        chk("rst_rdata0", 8'(bus.rdata0), 8'd0);
        chk("rst_rdata1", 8'(bus.rdata1), 8'd0);
        chk("rst_owner", 8'(bus.owner), 8'd0);
        chk("rst_lock_timeout", 8'(bus.lock_timeout), 8'd0);
        q0.delete();
        q1.delete();
        pend0 = 1'b0;
        pend1 = 1'b0;
        last0 = 4'd0;
        last1 = 4'd0;
    endtask

    // Asserts reset immediately, checks the async clear, releases on a falling edge.
    task automatic do_reset();
        idle_all();
        reset = 1'b0;
        #1;
        rst_check();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        #1 reset = 1'b0;
        #12;
        rst_check();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Host write then CPU read of the same word.
        drv(1, 1'b1, 1'b1, 1'b0, 4'd3, 4'hA);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        drv(1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        drv(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        idle_all();
        cycle(1'b0, 1'b0, 2'b00, 1'b0);

        // Preload addresses 0 and 1.
        drv(1, 1'b1, 1'b1, 1'b0, 4'd0, 4'h5);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        drv(1, 1'b1, 1'b1, 1'b0, 4'd1, 4'h6);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        idle_all();
        cycle(1'b0, 1'b0, 2'b00, 1'b0);

        // Round robin from a fresh reset: port 0 first.
        do_reset();
        drv(0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        drv(1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        idle_all();
        cycle(1'b0, 1'b0, 2'b00, 1'b0);

        // Locked read-read-write by port 0 with port 1 waiting.
        drv(0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        drv(1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0);
        cycle(1'b1, 1'b0, 2'b01, 1'b0);
        drv(0, 1'b1, 1'b1, 1'b0, 4'd2, 4'h9);
        cycle(1'b1, 1'b0, 2'b01, 1'b0);
        drv(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        drv(1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        idle_all();
        cycle(1'b0, 1'b0, 2'b00, 1'b0);

        // Lock timeout: 8 owned cycles, then a grant-free release cycle.
        drv(0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0);
        drv(1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 2'b01, 1'b0);
        cycle(1'b0, 1'b0, 2'b01, 1'b0);
        cycle(1'b0, 1'b1, 2'b00, 1'b1);
        idle_all();
        cycle(1'b0, 1'b0, 2'b00, 1'b0);

        // Reset right after a read grant loses the read.
        drv(1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        do_reset();
        drv(0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0);
        drv(1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        drv(0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        cycle(1'b0, 1'b1, 2'b00, 1'b0);
        idle_all();
        cycle(1'b0, 1'b0, 2'b00, 1'b0);

        // Back-to-back write/read of the top address on one port.
        drv(0, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        drv(0, 1'b1, 1'b0, 1'b0, 4'hF, 4'd0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0);
        idle_all();
        cycle(1'b0, 1'b0, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
